// File: rtl/vending_machine.sv
// Keypad-driven vending credit controller: synchronizes the active-low key
// lines, accepts one action per press, keeps a 3-digit BCD credit and drives
// three seven-segment digits.
module vending_machine (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [6:0] D0,
  output logic [6:0] D1,
  output logic [6:0] D2,
  output logic [3:0] key_value
);

  // state | meaning
  // IDLE  | waiting for a single valid key press
  // HELD  | key action done, waiting for all keys released
  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  localparam logic [3:0] KEY_INS5   = 4'd1;
  localparam logic [3:0] KEY_INS10  = 4'd2;
  localparam logic [3:0] KEY_BUY    = 4'd3;
  localparam logic [3:0] KEY_CANCEL = 4'd4;

  state_t     state_q, state_d;
  logic [3:0] row_meta_q, row_s_q;
  logic [3:0] dig0_q, dig1_q, dig2_q;
  logic [3:0] dig0_d, dig1_d, dig2_d;
  logic [3:0] key_q, key_d;
  logic [3:0] key_code;

  logic [3:0] add0, add1;
  logic [4:0] sum0, sum1, sum2;
  logic       c0, c1, c2;
  logic [3:0] a0, a1, a2;

  logic       b0, b1, ge25;
  logic [3:0] t_need;
  logic [3:0] s0, s1, s2;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  // Two-flop synchronizer for the asynchronous key lines; idles released.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_q <= 4'b1111;
      row_s_q    <= 4'b1111;
    end else begin
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
    end
  end

  // Decode exactly-one-low key lines; anything else yields code 0 (no key).
  always_comb begin
    key_code = 4'd0;
    case (row_s_q)
      4'b1110: key_code = KEY_INS5;
      4'b1101: key_code = KEY_INS10;
      4'b1011: key_code = KEY_BUY;
      4'b0111: key_code = KEY_CANCEL;
      default: key_code = 4'd0;
    endcase
  end

  // BCD add of 5 or 10; a carry out of the hundreds digit means > 995.
  always_comb begin
    add0 = (key_code == KEY_INS5)  ? 4'd5 : 4'd0;
    add1 = (key_code == KEY_INS10) ? 4'd1 : 4'd0;
    sum0 = {1'b0, dig0_q} + {1'b0, add0};
    c0   = (sum0 > 5'd9);
    a0   = c0 ? 4'(sum0 - 5'd10) : sum0[3:0];
    sum1 = {1'b0, dig1_q} + {1'b0, add1} + {4'd0, c0};
    c1   = (sum1 > 5'd9);
    a1   = c1 ? 4'(sum1 - 5'd10) : sum1[3:0];
    sum2 = {1'b0, dig2_q} + {4'd0, c1};
    c2   = (sum2 > 5'd9);
    a2   = c2 ? 4'(sum2 - 5'd10) : sum2[3:0];
  end

  // BCD subtract of 25; BCD digit order compares like plain binary.
  always_comb begin
    ge25   = ({dig2_q, dig1_q, dig0_q} >= 12'h025);
    b0     = (dig0_q < 4'd5);
    s0     = b0 ? (dig0_q + 4'd5) : (dig0_q - 4'd5);
    t_need = 4'd2 + {3'd0, b0};
    b1     = (dig1_q < t_need);
    s1     = b1 ? (dig1_q + 4'd10 - t_need) : (dig1_q - t_need);
    s2     = dig2_q - {3'd0, b1};
  end

  // Key FSM next state and credit/key updates; one action per press.
  always_comb begin
    state_d = state_q;
    dig0_d  = dig0_q;
    dig1_d  = dig1_q;
    dig2_d  = dig2_q;
    key_d   = key_q;
    case (state_q)
      IDLE: begin
        if (key_code != 4'd0) begin
          state_d = HELD;
          key_d   = key_code;
          case (key_code)
            KEY_INS5, KEY_INS10: begin
              if (!c2) begin
                dig0_d = a0;
                dig1_d = a1;
                dig2_d = a2;
              end
            end
            KEY_BUY: begin
              if (ge25) begin
                dig0_d = s0;
                dig1_d = s1;
                dig2_d = s2;
              end
            end
            KEY_CANCEL: begin
              dig0_d = 4'd0;
              dig1_d = 4'd0;
              dig2_d = 4'd0;
            end
            default: ;
          endcase
        end
      end
      HELD: begin
        if (row_s_q == 4'b1111) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, credit and key registers with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dig0_q  <= 4'd0;
      dig1_q  <= 4'd0;
      dig2_q  <= 4'd0;
      key_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      dig0_q  <= dig0_d;
      dig1_q  <= dig1_d;
      dig2_q  <= dig2_d;
      key_q   <= key_d;
    end
  end

  // Display decode is purely combinational from the digit registers.
  always_comb begin
    D0        = seg7(dig0_q);
    D1        = seg7(dig1_q);
    D2        = seg7(dig2_q);
    key_value = key_q;
  end

endmodule

// File: tb/tb_vending_machine.sv
// Bench for vending_machine: directed scenarios plus random key traffic,
// compared each cycle against a credit/press reference model.
module tb_vending_machine;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [6:0] D0, D1, D2;
  logic [3:0] key_value;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: integer credit, last key, pressed flag, 2-deep delay.
  int         m_credit;
  int         m_key;
  bit         m_held;
  logic [3:0] m_s1, m_s2;
  logic [6:0] seg_tab [10];

  localparam logic [6:0] SEG0 = 7'b0111111;
  localparam logic [6:0] SEG1 = 7'b0000110;
  localparam logic [6:0] SEG2 = 7'b1011011;
  localparam logic [6:0] SEG5 = 7'b1101101;
  localparam logic [6:0] SEG9 = 7'b1101111;

  vending_machine dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .D0        (D0),
    .D1        (D1),
    .D2        (D2),
    .key_value (key_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int key_of(input logic [3:0] s);
    int k;
    k = 0;
    if ($countones(~s) == 1) begin
      for (int i = 0; i < 4; i++)
        if (s[i] == 1'b0) k = i + 1;
    end
    return k;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int k;
    if (reset) begin
      m_credit = 0;
      m_key    = 0;
      m_held   = 0;
      m_s1     = 4'hF;
      m_s2     = 4'hF;
    end else begin
      if (!m_held) begin
        k = key_of(m_s2);
        if (k != 0) begin
          m_held = 1;
          m_key  = k;
          case (k)
            1: if (m_credit + 5  <= 995) m_credit += 5;
            2: if (m_credit + 10 <= 995) m_credit += 10;
            3: if (m_credit >= 25) m_credit -= 25;
            default: m_credit = 0;
          endcase
        end
      end else if (m_s2 == 4'hF) begin
        m_held = 0;
      end
      m_s2 = m_s1;
      m_s1 = row;
    end
  endtask

  task automatic tick(input logic [3:0] r, input logic rst);
    @(negedge clk);
    row   = r;
    reset = rst;
    @(posedge clk);
    model_edge();
    #1;
    chk("D0",  D0, seg_tab[m_credit % 10]);
    chk("D1",  D1, seg_tab[(m_credit / 10) % 10]);
    chk("D2",  D2, seg_tab[m_credit / 100]);
    chk("key", {3'b000, key_value}, 7'(m_key));
  endtask

  task automatic press(input logic [3:0] r, input int hold);
    repeat (hold) tick(r, 1'b0);
    repeat (3) tick(4'hF, 1'b0);
  endtask

  initial begin
    logic [3:0] r;
    int         sel;
    int         hold;

    seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110;
    seg_tab[2] = 7'b1011011; seg_tab[3] = 7'b1001111;
    seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
    seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111;
    seg_tab[8] = 7'b1111111; seg_tab[9] = 7'b1101111;
    m_credit = 0; m_key = 0; m_held = 0; m_s1 = 4'hF; m_s2 = 4'hF;
    reset = 1'b1;
    row   = 4'hF;

    // Reset and idle
    repeat (2) tick(4'hF, 1'b1);
    chk("rst_D0", D0, SEG0);
    chk("rst_D1", D1, SEG0);
    chk("rst_D2", D2, SEG0);
    chk("rst_key", {3'b000, key_value}, 7'd0);
    repeat (10) tick(4'hF, 1'b0);
    chk("idle_D0", D0, SEG0);
    chk("idle_key", {3'b000, key_value}, 7'd0);

    // Insert 5 then 10 -> 015
    press(4'b1110, 3);
    press(4'b1101, 3);
    chk("c015_D1", D1, SEG1);
    chk("c015_D0", D0, SEG5);
    chk("c015_key", {3'b000, key_value}, 7'd2);

    // Rejected buy, insert 10, buy -> 000
    press(4'b1011, 3);
    chk("nobuy_D0", D0, SEG5);
    chk("nobuy_key", {3'b000, key_value}, 7'd3);
    press(4'b1101, 3);
    chk("c025_D1", D1, SEG2);
    chk("c025_D0", D0, SEG5);
    press(4'b1011, 3);
    chk("buy_D1", D1, SEG0);
    chk("buy_D0", D0, SEG0);

    // Long hold counts once
    press(4'b1110, 20);
    chk("hold_D0", D0, SEG5);
    chk("hold_D1", D1, SEG0);
    press(4'b1110, 3);
    chk("c010_D1", D1, SEG1);
    chk("c010_D0", D0, SEG0);

    // Fill to 995, overflow rejected, cancel
    repeat (98) press(4'b1101, 2);
    press(4'b1110, 2);
    chk("c995_D2", D2, SEG9);
    chk("c995_D1", D1, SEG9);
    chk("c995_D0", D0, SEG5);
    press(4'b1110, 2);
    chk("ovf_D0", D0, SEG5);
    chk("ovf_D2", D2, SEG9);
    chk("ovf_key", {3'b000, key_value}, 7'd1);
    press(4'b1101, 2);
    chk("ovf10_D1", D1, SEG9);
    press(4'b0111, 3);
    chk("cancel_D2", D2, SEG0);
    chk("cancel_D0", D0, SEG0);
    chk("cancel_key", {3'b000, key_value}, 7'd4);

    // Multi-key pattern ignored
    repeat (5) tick(4'b1100, 1'b0);
    repeat (3) tick(4'hF, 1'b0);
    chk("multi_key", {3'b000, key_value}, 7'd4);
    chk("multi_D0", D0, SEG0);

    // Key held through reset is accepted once after release
    press(4'b1101, 2);
    tick(4'b1110, 1'b1);
    tick(4'b1110, 1'b1);
    chk("rstkey_D1", D1, SEG0);
    chk("rstkey_key", {3'b000, key_value}, 7'd0);
    repeat (5) tick(4'b1110, 1'b0);
    chk("rstkey_D0", D0, SEG5);
    chk("rstkey_key1", {3'b000, key_value}, 7'd1);
    repeat (3) tick(4'hF, 1'b0);

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5) begin
        r = 4'hF;
        r[$urandom_range(0, 3)] = 1'b0;
      end else if (sel < 7) begin
        r = 4'($urandom_range(0, 15));
      end else begin
        r = 4'hF;
      end
      hold = int'($urandom_range(1, 4));
      for (int h = 0; h < hold; h++)
        tick(r, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end
    repeat (4) tick(4'hF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
